// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode map, control-word layout and per-opcode decode helper
// shared by the decode stage and its scoreboard.
package cpu_pkg;

  localparam int OPC_W = 5;

  // Register ALU ops
  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_OR      = 5'd3;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_NOT     = 5'd5;
  localparam logic [4:0] OP_SHL     = 5'd6;
  localparam logic [4:0] OP_SHR     = 5'd7;
  // Immediate ALU ops
  localparam logic [4:0] OP_ADDI    = 5'd8;
  localparam logic [4:0] OP_SUBI    = 5'd9;
  localparam logic [4:0] OP_ANDI    = 5'd10;
  localparam logic [4:0] OP_ORI     = 5'd11;
  localparam logic [4:0] OP_XORI    = 5'd12;
  localparam logic [4:0] OP_SHLI    = 5'd13;
  localparam logic [4:0] OP_SHRI    = 5'd14;
  localparam logic [4:0] OP_MUL     = 5'd15;
  localparam logic [4:0] OP_DIV     = 5'd16;
  localparam logic [4:0] OP_MULI    = 5'd17;
  localparam logic [4:0] OP_DIVI    = 5'd18;
  // Branches
  localparam logic [4:0] OP_BEQ     = 5'd19;
  localparam logic [4:0] OP_BNE     = 5'd20;
  localparam logic [4:0] OP_BGE     = 5'd21;
  localparam logic [4:0] OP_BLT     = 5'd22;
  // Compares into the semaphore flag
  localparam logic [4:0] OP_CEQ     = 5'd23;
  localparam logic [4:0] OP_CNE     = 5'd24;
  localparam logic [4:0] OP_CGE     = 5'd25;
  localparam logic [4:0] OP_CLT     = 5'd26;
  // Memory, semaphore, jump
  localparam logic [4:0] OP_LD      = 5'd27;
  localparam logic [4:0] OP_ST      = 5'd28;
  localparam logic [4:0] OP_SEMA_RD = 5'd29;
  localparam logic [4:0] OP_SEMA_WR = 5'd30;
  localparam logic [4:0] OP_JALR    = 5'd31;

  // MSB first: alu_src ... sema_write
  typedef struct packed {
    logic alu_src;
    logic mem_branch;
    logic mem_write;
    logic mem_read;
    logic reg_write;
    logic mem_to_reg;
    logic sema_read;
    logic sema_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  use_rs1;
    logic  use_rs2;
    logic  imm_i;   // immediate taken from the i_imm field
    logic  imm_b;   // immediate taken from the split b_imm field
  } dec_t;

  function automatic dec_t decode_op(input logic [4:0] op);
    dec_t d;
    d = '0;
    d.use_rs1 = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_DIV: begin
        d.ctrl.reg_write = 1'b1;
        d.use_rs2        = 1'b1;
      end
      OP_NOT: d.ctrl.reg_write = 1'b1;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SHLI, OP_SHRI, OP_MULI, OP_DIVI: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.imm_i          = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGE, OP_BLT: begin
        d.ctrl.mem_branch = 1'b1;
        d.use_rs2         = 1'b1;
        d.imm_b           = 1'b1;
      end
      OP_CEQ, OP_CNE, OP_CGE, OP_CLT: begin
        d.ctrl.sema_write = 1'b1;
        d.use_rs2         = 1'b1;
      end
      OP_LD: begin
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.use_rs1         = 1'b0;
        d.imm_i           = 1'b1;
      end
      OP_ST: begin
        d.ctrl.mem_write = 1'b1;
        d.imm_i          = 1'b1;
      end
      OP_SEMA_RD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.sema_read = 1'b1;
        d.use_rs1        = 1'b0;
      end
      OP_SEMA_WR: d.ctrl.sema_write = 1'b1;
      OP_JALR: begin
        d.ctrl.mem_branch = 1'b1;
        d.ctrl.reg_write  = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: one busy bit per register, tracking writes that have
// been issued but not yet retired, and the resulting issue hazard.
// Ports:
//   clk, rst                     clock, async active-high reset
//   set_i / set_id_i             mark a destination busy (issue)
//   clr_wb_i / clr_wb_id_i       retire from writeback
//   clr_fl_i / clr_fl_id_i       squash of the instruction held in decode
//   rs1/rs2/rd _use_i, _id_i     operands of the candidate instruction
//   hazard_o                     candidate must not issue this cycle
module decode_scoreboard #(
  parameter int REG_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [REG_ID_W-1:0] set_id_i,
  input  logic                clr_wb_i,
  input  logic [REG_ID_W-1:0] clr_wb_id_i,
  input  logic                clr_fl_i,
  input  logic [REG_ID_W-1:0] clr_fl_id_i,
  input  logic                rs1_use_i,
  input  logic [REG_ID_W-1:0] rs1_id_i,
  input  logic                rs2_use_i,
  input  logic [REG_ID_W-1:0] rs2_id_i,
  input  logic                rd_use_i,
  input  logic [REG_ID_W-1:0] rd_id_i,
  output logic                hazard_o
);

  localparam int NREG = 2 ** REG_ID_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr_mask, set_mask, busy_eff;

  always_comb begin
    clr_mask = '0;
    if (clr_wb_i) clr_mask[clr_wb_id_i] = 1'b1;
    if (clr_fl_i) clr_mask[clr_fl_id_i] = 1'b1;
  end

  // A bit retiring this cycle already counts as free for the hazard check.
  assign busy_eff = busy_q & ~clr_mask;

  assign hazard_o = (rs1_use_i & busy_eff[rs1_id_i]) |
                    (rs2_use_i & busy_eff[rs2_id_i]) |
                    (rd_use_i  & busy_eff[rd_id_i]);

  // Kept apart from the hazard path: set_i depends on hazard_o through accept.
  always_comb begin
    set_mask = '0;
    if (set_i) set_mask[set_id_i] = 1'b1;
    set_mask[0] = 1'b0;
    busy_d = busy_eff | set_mask;  // set wins over a same-cycle clear
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register file, writeback bypass and
// scoreboard-based issue stall; one-entry output register with valid/ready.
// Ports:
//   clk, rst                          clock, async active-high reset
//   flush                             squash the held instruction
//   in_valid/in_ready, instr          instruction input handshake
//   wb_valid, wb_we, wb_rd_id, wb_data  retire / regfile write
//   out_valid/out_ready               output handshake
//   out_opcode, out_ctrl, out_rd_id, out_rs1, out_rs2, out_imm  decoded fields
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ID_W   = 4,
  parameter int IMM_W      = 8,
  parameter int IMM_SIGNED = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [5+2*REG_ID_W+IMM_W-1:0]       instr,
  input  logic                                wb_valid,
  input  logic                                wb_we,
  input  logic [REG_ID_W-1:0]                 wb_rd_id,
  input  logic [DATA_W-1:0]                   wb_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OPC_W-1:0]                    out_opcode,
  output logic [7:0]                          out_ctrl,
  output logic [REG_ID_W-1:0]                 out_rd_id,
  output logic [DATA_W-1:0]                   out_rs1,
  output logic [DATA_W-1:0]                   out_rs2,
  output logic [DATA_W-1:0]                   out_imm
);

  localparam int NREG    = 2 ** REG_ID_W;
  localparam int INSTR_W = 5 + 2 * REG_ID_W + IMM_W;

  // Field extraction; the immediate overlaps the upper register fields.
  logic [OPC_W-1:0]    op;
  logic [REG_ID_W-1:0] rd_id, rs1_id, rs2_id;
  logic [IMM_W-1:0]    i_imm, b_imm, imm_raw;
  logic [DATA_W-1:0]   imm_ext;
  dec_t                dec;

  assign op     = instr[OPC_W-1:0];
  assign rd_id  = instr[5 +: REG_ID_W];
  assign rs1_id = instr[5+REG_ID_W +: REG_ID_W];
  assign rs2_id = instr[5+2*REG_ID_W +: REG_ID_W];
  assign i_imm  = instr[INSTR_W-1 -: IMM_W];
  assign b_imm  = {instr[INSTR_W-1 -: IMM_W-REG_ID_W], rd_id};
  assign dec    = decode_op(op);

  always_comb begin
    imm_raw = '0;
    if (dec.imm_i)      imm_raw = i_imm;
    else if (dec.imm_b) imm_raw = b_imm;
    if (IMM_SIGNED != 0) imm_ext = DATA_W'(signed'(imm_raw));
    else                 imm_ext = DATA_W'(imm_raw);
  end

  // Register file; r0 is never written so it always reads zero.
  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  assign wr_en = wb_valid & wb_we & (wb_rd_id != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wb_rd_id] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (dec.use_rs1 && rs1_id != '0)
      rs1_val = (wr_en && wb_rd_id == rs1_id) ? wb_data : regs_q[rs1_id];
    if (dec.use_rs2 && rs2_id != '0)
      rs2_val = (wr_en && wb_rd_id == rs2_id) ? wb_data : regs_q[rs2_id];
  end

  // Output register state
  logic                out_valid_q;
  logic [OPC_W-1:0]    out_opcode_q;
  ctrl_t               out_ctrl_q;
  logic [REG_ID_W-1:0] out_rd_id_q;
  logic [DATA_W-1:0]   out_rs1_q, out_rs2_q, out_imm_q;

  logic hazard, accept, fl_clr;

  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  // Squashing the held instruction releases its destination.
  assign fl_clr   = flush & out_valid_q & out_ctrl_q.reg_write;

  decode_scoreboard #(.REG_ID_W(REG_ID_W)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_i       (accept & dec.ctrl.reg_write),
    .set_id_i    (rd_id),
    .clr_wb_i    (wb_valid),
    .clr_wb_id_i (wb_rd_id),
    .clr_fl_i    (fl_clr),
    .clr_fl_id_i (out_rd_id_q),
    .rs1_use_i   (dec.use_rs1),
    .rs1_id_i    (rs1_id),
    .rs2_use_i   (dec.use_rs2),
    .rs2_id_i    (rs2_id),
    .rd_use_i    (dec.ctrl.reg_write),
    .rd_id_i     (rd_id),
    .hazard_o    (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_ctrl_q   <= '0;
      out_rd_id_q  <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_imm_q    <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_opcode_q <= op;
      out_ctrl_q   <= dec.ctrl;
      out_rd_id_q  <= rd_id;
      out_rs1_q    <= rs1_val;
      out_rs2_q    <= rs2_val;
      out_imm_q    <= imm_ext;
    end else if (flush || out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_rd_id  = out_rd_id_q;
  assign out_rs1    = out_rs1_q;
  assign out_rs2    = out_rs2_q;
  assign out_imm    = out_imm_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clk, rst, flush, in_valid, instr_dummy;
  logic        in_ready, in_ready_s;
  logic [20:0] instr;
  logic        wb_valid, wb_we;
  logic [3:0]  wb_rd_id;
  logic [15:0] wb_data;
  logic        out_ready;
  logic        out_valid, out_valid_s;
  logic [4:0]  out_opcode, out_opcode_s;
  logic [7:0]  out_ctrl, out_ctrl_s;
  logic [3:0]  out_rd_id, out_rd_id_s;
  logic [15:0] out_rs1, out_rs2, out_imm, out_rs1_s, out_rs2_s, out_imm_s;

  int chk = 0;
  int fails = 0;

  decode_stage #(.DATA_W(16), .REG_ID_W(4), .IMM_W(8), .IMM_SIGNED(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_id(wb_rd_id),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_ctrl(out_ctrl), .out_rd_id(out_rd_id),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm));

  decode_stage #(.DATA_W(16), .REG_ID_W(4), .IMM_W(8), .IMM_SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .instr(instr), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_id(wb_rd_id),
    .wb_data(wb_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_opcode(out_opcode_s), .out_ctrl(out_ctrl_s), .out_rd_id(out_rd_id_s),
    .out_rs1(out_rs1_s), .out_rs2(out_rs2_s), .out_imm(out_imm_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2f,
                                     input logic [3:0] hi);
    return {hi, rs2f, rs1, rd, op};
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] mregs [16];
  logic [15:0] mbusy;
  bit          mov;
  logic [4:0]  e_op;
  logic [7:0]  e_ctrl;
  logic [3:0]  e_rd;
  logic [15:0] e_rs1, e_rs2, e_imm, e_imm_s;

  // Control word, operand use and immediate source straight from the opcode table.
  function automatic void ref_decode(input int op, output logic [7:0] c, output bit u1,
                                     output bit u2, output int isel);
    c = 8'h00; u1 = (op != 27 && op != 29); u2 = 0; isel = 0;
    if (op <= 7 || op == 15 || op == 16) begin c = 8'h08; u2 = (op != 5); end
    else if (op <= 14 || op == 17 || op == 18) begin c = 8'h88; isel = 1; end
    else if (op <= 22) begin c = 8'h40; u2 = 1; isel = 2; end
    else if (op <= 26) begin c = 8'h01; u2 = 1; end
    else if (op == 27) begin c = 8'h1C; isel = 1; end
    else if (op == 28) begin c = 8'h20; isel = 1; end
    else if (op == 29) c = 8'h0A;
    else if (op == 30) c = 8'h01;
    else c = 8'h48;
  endfunction

  function automatic logic [15:0] rv(input logic [3:0] s, input bit wq);
    if (s == 4'd0) return 16'h0000;
    if (wq && s == wb_rd_id) return wb_data;
    return mregs[s];
  endfunction

  task automatic idle_inputs();
    flush = 0; in_valid = 0; instr = '0; wb_valid = 0; wb_we = 0;
    wb_rd_id = '0; wb_data = '0; out_ready = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1; in_valid = 1; instr = mk(OP_ADD, 1, 0, 0, 0);
    repeat (2) tick();
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
    chk++; if ({out_opcode, out_ctrl, out_rd_id, out_rs1, out_rs2, out_imm} !== '0) begin fails++; $display("FAIL reset_outputs got nonzero op=%0h ctrl=%0h imm=%0h", out_opcode, out_ctrl, out_imm); end
    chk++; if (dut.u_sb.busy_q !== 16'h0) begin fails++; $display("FAIL reset_busy got %0h want 0", dut.u_sb.busy_q); end
    rst = 0; in_valid = 0;
    #1;
    chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %0h want 1", in_ready); end
    tick();
  endtask

  task automatic test_bypass_read();
    wb_valid = 1; wb_we = 1; wb_rd_id = 3; wb_data = 16'h1234;
    tick();
    wb_valid = 0; wb_we = 0;
    instr = mk(OP_ADD, 5, 3, 0, 0); in_valid = 1; out_ready = 1;
    #1;
    chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready got %0h want 1", in_ready); end
    tick();
    in_valid = 0;
    chk++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got %0h want 1", out_valid); end
    chk++; if (out_rs1 !== 16'h1234) begin fails++; $display("FAIL add_rs1 got %0h want 1234", out_rs1); end
    chk++; if (out_rs2 !== 16'h0000) begin fails++; $display("FAIL add_rs2 got %0h want 0", out_rs2); end
    chk++; if (out_ctrl !== 8'h08) begin fails++; $display("FAIL add_ctrl got %0h want 08", out_ctrl); end
    chk++; if (out_rd_id !== 4'd5 || out_opcode !== OP_ADD) begin fails++; $display("FAIL add_fields got rd=%0d op=%0d want rd=5 op=0", out_rd_id, out_opcode); end
    chk++; if (dut.u_sb.busy_q !== 16'h0020) begin fails++; $display("FAIL add_busy got %0h want 0020", dut.u_sb.busy_q); end
  endtask

  task automatic test_raw_hazard();
    instr = mk(OP_SUB, 6, 5, 0, 0); in_valid = 1;
    #1;
    chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall0 got %0h want 0", in_ready); end
    tick();
    chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall1 got %0h want 0", in_ready); end
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL handoff_clear got %0h want 0", out_valid); end
    wb_valid = 1; wb_we = 1; wb_rd_id = 5; wb_data = 16'h0007;
    #1;
    chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_release got %0h want 1", in_ready); end
    tick();
    wb_valid = 0; wb_we = 0; in_valid = 0;
    chk++; if (out_valid !== 1'b1 || out_opcode !== OP_SUB) begin fails++; $display("FAIL sub_issue got v=%0h op=%0d want v=1 op=1", out_valid, out_opcode); end
    chk++; if (out_rs1 !== 16'h0007) begin fails++; $display("FAIL sub_bypass got %0h want 0007", out_rs1); end
    chk++; if (dut.u_sb.busy_q !== 16'h0040) begin fails++; $display("FAIL sub_busy got %0h want 0040", dut.u_sb.busy_q); end
  endtask

  task automatic test_imm_ext();
    // retire r6 while ADDI issues
    wb_valid = 1; wb_we = 0; wb_rd_id = 6;
    instr = mk(OP_ADDI, 1, 0, 4'h0, 4'hF); in_valid = 1;
    tick();
    chk++; if (out_imm !== 16'h00F0) begin fails++; $display("FAIL addi_imm_zx got %0h want 00F0", out_imm); end
    chk++; if (out_imm_s !== 16'hFFF0) begin fails++; $display("FAIL addi_imm_sx got %0h want FFF0", out_imm_s); end
    chk++; if (out_ctrl !== 8'h88) begin fails++; $display("FAIL addi_ctrl got %0h want 88", out_ctrl); end
    chk++; if (dut.u_sb.busy_q !== 16'h0002) begin fails++; $display("FAIL addi_busy got %0h want 0002", dut.u_sb.busy_q); end
  endtask

  task automatic test_branch_imm();
    // r1 retires the same cycle BEQ reads it: no stall expected
    wb_valid = 1; wb_we = 0; wb_rd_id = 1;
    instr = mk(OP_BEQ, 3, 1, 2, 4'hA); in_valid = 1;
    #1;
    chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL beq_clear_same_cycle got %0h want 1", in_ready); end
    tick();
    wb_valid = 0; in_valid = 0;
    chk++; if (out_imm !== 16'h00A3) begin fails++; $display("FAIL beq_imm got %0h want 00A3", out_imm); end
    chk++; if (out_imm_s !== 16'hFFA3) begin fails++; $display("FAIL beq_imm_sx got %0h want FFA3", out_imm_s); end
    chk++; if (out_ctrl !== 8'h40) begin fails++; $display("FAIL beq_ctrl got %0h want 40", out_ctrl); end
    chk++; if (dut.u_sb.busy_q !== 16'h0000) begin fails++; $display("FAIL beq_busy got %0h want 0", dut.u_sb.busy_q); end
    tick();
  endtask

  task automatic test_stall_flush();
    out_ready = 0;
    instr = mk(OP_LD, 4, 7, 5, 4'h2); in_valid = 1;
    tick();
    instr = mk(OP_ADD, 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk++; if (out_valid !== 1'b1 || out_opcode !== OP_LD || out_rd_id !== 4'd4) begin fails++; $display("FAIL stall_hold%0d got v=%0h op=%0d rd=%0d", i, out_valid, out_opcode, out_rd_id); end
      chk++; if (out_ctrl !== 8'h1C || out_imm !== 16'h0025 || out_rs1 !== 16'h0) begin fails++; $display("FAIL stall_fields%0d got ctrl=%0h imm=%0h rs1=%0h", i, out_ctrl, out_imm, out_rs1); end
      chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready%0d got %0h want 0", i, in_ready); end
      tick();
    end
    flush = 1;
    #1;
    chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %0h want 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0h want 0", out_valid); end
    chk++; if (dut.u_sb.busy_q !== 16'h0000) begin fails++; $display("FAIL flush_busy got %0h want 0", dut.u_sb.busy_q); end
  endtask

  task automatic test_reset_mid();
    wb_valid = 1; wb_we = 1; wb_rd_id = 2; wb_data = 16'h55AA;
    tick();
    wb_valid = 0; wb_we = 0;
    out_ready = 0; instr = mk(OP_ADD, 2, 0, 0, 0); in_valid = 1;
    tick();
    in_valid = 0;
    chk++; if (out_valid !== 1'b1 || dut.u_sb.busy_q !== 16'h0004) begin fails++; $display("FAIL rstmid_pre got v=%0h busy=%0h want 1/0004", out_valid, dut.u_sb.busy_q); end
    #2; rst = 1; #1;
    chk++; if (out_valid !== 1'b0 || {out_opcode, out_ctrl, out_rd_id} !== '0) begin fails++; $display("FAIL rstmid_out got v=%0h op=%0h ctrl=%0h", out_valid, out_opcode, out_ctrl); end
    chk++; if (dut.u_sb.busy_q !== 16'h0 || in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_sb got busy=%0h rdy=%0h", dut.u_sb.busy_q, in_ready); end
    tick();
    rst = 0; out_ready = 1; instr = mk(OP_ADD, 1, 2, 2, 0); in_valid = 1;
    #1;
    chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %0h want 1", in_ready); end
    tick();
    in_valid = 0;
    chk++; if (out_valid !== 1'b1 || out_rs1 !== 16'h0 || out_rs2 !== 16'h0) begin fails++; $display("FAIL rstmid_r2 got v=%0h rs1=%0h rs2=%0h", out_valid, out_rs1, out_rs2); end
    wb_valid = 1; wb_we = 0; wb_rd_id = 1;
    tick();
    wb_valid = 0;
  endtask

  task automatic test_random();
    logic [7:0]  c, raw;
    logic [3:0]  rd, s1, s2;
    logic [15:0] clr, eb;
    bit u1, u2, wq, hz, rdy, acc;
    int isel, st;
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mbusy = '0; mov = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr = mk(5'($urandom_range(0, 31)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      wb_valid = 0; wb_we = 0; wb_rd_id = '0; wb_data = 16'($urandom);
      if (mbusy != 0 && $urandom_range(0, 1) == 1) begin
        st = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++)
          if (!wb_valid && mbusy[(st + k) % 16]) begin wb_valid = 1; wb_rd_id = 4'((st + k) % 16); end
        wb_we = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 7) == 0) begin
        wb_valid = 1; wb_we = $urandom_range(0, 1); wb_rd_id = 4'($urandom_range(0, 15));
      end
      #1;
      ref_decode(int'(instr[4:0]), c, u1, u2, isel);
      rd = instr[8:5]; s1 = instr[12:9]; s2 = instr[16:13];
      wq = wb_valid && wb_we && wb_rd_id != 0;
      clr = '0;
      if (wb_valid) clr[wb_rd_id] = 1'b1;
      if (flush && mov && e_ctrl[3]) clr[e_rd] = 1'b1;
      eb = mbusy & ~clr;
      hz = (u1 && eb[s1]) || (u2 && eb[s2]) || (c[3] && eb[rd]);
      rdy = !flush && !hz && (!mov || out_ready);
      acc = in_valid && rdy;
      chk++; if (in_ready !== rdy) begin fails++; $display("FAIL rnd_in_ready cyc=%0d got %0h want %0h", cyc, in_ready, rdy); end
      if (acc) begin
        raw = (isel == 1) ? {instr[20:17], instr[16:13]} : (isel == 2) ? {instr[20:17], rd} : 8'h00;
        e_op = instr[4:0]; e_ctrl = c; e_rd = rd;
        e_rs1 = u1 ? rv(s1, wq) : 16'h0;
        e_rs2 = u2 ? rv(s2, wq) : 16'h0;
        e_imm = {8'h00, raw}; e_imm_s = {{8{raw[7]}}, raw};
      end
      if (wq) mregs[wb_rd_id] = wb_data;
      mbusy = eb;
      if (acc && c[3] && rd != 0) mbusy[rd] = 1'b1;
      mov = acc ? 1'b1 : ((flush || out_ready) ? 1'b0 : mov);
      tick();
      chk++; if (out_valid !== mov) begin fails++; $display("FAIL rnd_out_valid cyc=%0d got %0h want %0h", cyc, out_valid, mov); end
      chk++; if (dut.u_sb.busy_q !== mbusy) begin fails++; $display("FAIL rnd_busy cyc=%0d got %0h want %0h", cyc, dut.u_sb.busy_q, mbusy); end
      if (mov) begin
        chk++; if (out_opcode !== e_op || out_ctrl !== e_ctrl || out_rd_id !== e_rd) begin fails++; $display("FAIL rnd_ctrl cyc=%0d got op=%0d ctrl=%0h rd=%0d want op=%0d ctrl=%0h rd=%0d", cyc, out_opcode, out_ctrl, out_rd_id, e_op, e_ctrl, e_rd); end
        chk++; if (out_rs1 !== e_rs1 || out_rs2 !== e_rs2) begin fails++; $display("FAIL rnd_operands cyc=%0d got %0h/%0h want %0h/%0h", cyc, out_rs1, out_rs2, e_rs1, e_rs2); end
        chk++; if (out_imm !== e_imm || out_imm_s !== e_imm_s) begin fails++; $display("FAIL rnd_imm cyc=%0d got %0h/%0h want %0h/%0h", cyc, out_imm, out_imm_s, e_imm, e_imm_s); end
      end
    end
  endtask

  initial begin
    instr_dummy = 0;
    test_reset();
    test_bypass_read();
    test_raw_hazard();
    test_imm_ext();
    test_branch_imm();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/operand width.
REQ-002 SHALL have parameter REG_ID_W, default 4, meaning register-id width; register count NREG = 2**REG_ID_W.
REQ-003 SHALL have parameter IMM_W, default 8, meaning immediate field width; INSTR_W = 5 + 2*REG_ID_W + IMM_W (default 21).
REQ-004 SHALL have parameter IMM_SIGNED, default 0, meaning 1 = sign-extend immediates, 0 = zero-extend.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports: clk in 1 (clock); rst in 1 (async reset).
REQ-006 SHALL have ports: flush in 1 (squash held instruction); in_valid in 1; in_ready out 1; instr in INSTR_W.
REQ-007 SHALL have ports: wb_valid in 1 (retire, clears scoreboard); wb_we in 1 (write regfile); wb_rd_id in REG_ID_W; wb_data in DATA_W.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_opcode out 5; out_ctrl out 8 {alu_src, mem_branch, mem_write, mem_read, reg_write, mem_to_reg, sema_read, sema_write}.
REQ-009 SHALL have ports: out_rd_id out REG_ID_W; out_rs1 out DATA_W; out_rs2 out DATA_W; out_imm out DATA_W.

Function
REQ-010 Fields: opcode = instr[4:0]; rd = instr[5 +: R]; rs1 = instr[5+R +: R]; rs2 = instr[5+2R +: R]; i_imm = instr[INSTR_W-1 -: IMM_W]; b_imm = {instr[INSTR_W-1 -: IMM_W-R], rd} (R = REG_ID_W).
REQ-011 Control bits per opcode SHALL be as follows; all other bits 0.
- ADD..SHR register ops (0-7, 15, 16): reg_write.
- Immediate ops (8-14, 17, 18): alu_src, reg_write.
- BEQ..BLT (19-22): mem_branch.
- CEQ..CLT (23-26): sema_write.
- LD (27): mem_read, reg_write, mem_to_reg.
- ST (28): mem_write.
- SEMA_RD (29): reg_write, sema_read.
- SEMA_WR (30): sema_write.
- JALR (31): mem_branch, reg_write.
REQ-012 Immediate: i_imm for immediate ops, LD and ST; b_imm for BEQ..BLT; 0 otherwise; extended to DATA_W per IMM_SIGNED.
REQ-013 rs1 use: all opcodes except LD and SEMA_RD; rs2 use: register ops except NOT, branches, compares; unused source outputs SHALL be 0.
REQ-014 Register 0 SHALL read 0; writes to it ignored; it is never marked busy.
REQ-015 Regfile write SHALL occur at posedge when wb_valid & wb_we & wb_rd_id != 0.
REQ-016 Read bypass: a source equal to a same-cycle qualifying write id SHALL return wb_data.
REQ-017 Scoreboard: one busy bit per register; set on accept when reg_write & rd != 0; cleared when wb_valid for wb_rd_id.
REQ-018 Same-cycle set and clear of one id: set SHALL win.
REQ-019 hazard = any used source busy, or (reg_write & rd busy); a bit being cleared this cycle counts as not busy.
REQ-020 in_ready = !flush & !hazard & (!out_valid | out_ready).
REQ-021 Accept (in_valid & in_ready) SHALL load all out_* registers next edge with out_valid = 1; latency 1 cycle.
REQ-022 Output SHALL hold stable while out_valid & !out_ready.
REQ-023 Handoff without accept SHALL clear out_valid.
REQ-024 Flush SHALL clear out_valid next edge and clear the busy bit of the held instruction if it is valid with reg_write, regardless of out_ready.
REQ-025 Downstream squashed instructions SHALL retire via wb_valid = 1, wb_we = 0.

Reset
REQ-026 While rst = 1, asynchronously: all out_* = 0, out_valid = 0, scoreboard = 0, all registers = 0; in_ready = 0.
REQ-027 Reset mid-operation SHALL discard the held instruction with no write; after deassertion, the first edge behaves as post-reset idle.

Structure
REQ-028 A shared package cpu_pkg SHALL hold the 32 opcode constants and a packed ctrl_t typedef (8 bits, REQ-008 order).
REQ-029 A sub-module decode_scoreboard (busy vector, set/clear, hazard) SHALL be instantiated; decode, regfile and bypass reside in decode_stage.

Verification
REQ-030 Scenario: write r3 = 0x1234 via wb; then ADD rd=5 rs1=3 rs2=0 -> next cycle out_rs1 = 0x1234, out_rs2 = 0, ctrl = reg_write, r5 busy.
REQ-031 Scenario: ADD rd=5, then SUB rs1=5 -> in_ready = 0 until wb_valid rd=5 data 0x0007; in the same cycle in_ready = 1 and SUB out_rs1 = 0x0007.
REQ-032 Scenario: ADDI with imm field 0xF0, IMM_SIGNED = 1 -> out_imm = 0xFFF0; with IMM_SIGNED = 0 -> out_imm = 0x00F0.
REQ-033 Scenario: BEQ with top imm nibble 0xA, rd field 0x3 -> out_imm = 0x00A3, ctrl = mem_branch, no busy bit set.
REQ-034 Scenario: out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0; then flush with held LD rd=4 -> out_valid = 0, r4 busy cleared.
REQ-035 Scenario: assert rst while out_valid = 1 and r2 busy -> outputs and scoreboard 0 immediately, r2 reads 0 afterward.
